pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destination registers after ID,
// detects load-use hazards, sequences multi-cycle EX occupancy, and produces
// registered per-operand forward selects for the instruction in EX.
//
// Issue handshake: the ID instruction is offered with id_valid and accepted
// (issue) in the same cycle only when there is no stall and no flush; an
// offered but unaccepted instruction stays in IF/ID while stall is high, or
// is dropped when flush is high.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int MC_W   = 4,
  parameter int FW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [MC_W-1:0]   id_mc_cycles,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic              ex_hold,
  output logic [FW-1:0]     ex_fwd_a,
  output logic [FW-1:0]     ex_fwd_b,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } entry_t;

  // Stage 1 is EX, stage DEPTH is WB.
  entry_t            tab_q [1:DEPTH];
  entry_t            tab_d [1:DEPTH];
  entry_t            new_e;
  logic [MC_W-1:0]   hold_q, hold_d;
  logic [FW-1:0]     fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [FW-1:0]     sel_a, sel_b;
  logic [15:0]       cnt_q, cnt_d;
  logic              load_use;
  logic              issue;

  // An entry only produces a value if it writes a non-zero register.
  function automatic logic hits(input entry_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

  // Hazard detection and issue decision.
  always_comb begin
    ex_hold  = (hold_q != '0);
    load_use = id_valid && tab_q[1].load &&
               ((id_rs_used && hits(tab_q[1], id_rs)) ||
                (id_rt_used && hits(tab_q[1], id_rt)));
    stall    = (load_use || ex_hold) && !flush;
    issue    = id_valid && !stall && !flush;
    bubble   = !issue && !ex_hold;
  end

  // Forward source search: scan oldest to youngest so the youngest match wins;
  // the WB stage is excluded because the register file writes through.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (id_rs_used && hits(tab_q[j], id_rs)) sel_a = FW'(j);
      if (id_rt_used && hits(tab_q[j], id_rt)) sel_b = FW'(j);
    end
  end

  // Next-state for the in-flight table, hold counter, forward selects, counter.
  always_comb begin
    new_e = '0;
    if (issue) begin
      new_e.valid    = 1'b1;
      new_e.rd       = id_rd;
      new_e.regwrite = id_regwrite;
      new_e.load     = id_memread;
    end

    for (int j = 1; j <= DEPTH; j++) tab_d[j] = tab_q[j];
    if (ex_hold) begin
      // EX keeps its instruction; a bubble drains into stage 2.
      tab_d[1] = tab_q[1];
      tab_d[2] = '0;
      for (int j = 3; j <= DEPTH; j++) tab_d[j] = tab_q[j-1];
    end else begin
      tab_d[1] = new_e;
      for (int j = 2; j <= DEPTH; j++) tab_d[j] = tab_q[j-1];
    end

    hold_d = hold_q;
    if (issue)        hold_d = id_mc_cycles;
    else if (ex_hold) hold_d = hold_q - MC_W'(1);

    fwd_a_d = '0;
    fwd_b_d = '0;
    if (ex_hold) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (issue) begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // State registers with synchronous reset; reset abandons any multi-cycle op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 1; j <= DEPTH; j++) tab_q[j] <= '0;
      hold_q  <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int j = 1; j <= DEPTH; j++) tab_q[j] <= tab_d[j];
      hold_q  <= hold_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_fwd_a  = fwd_a_q;
  assign ex_fwd_b  = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of per-cycle vectors plus hand-written
// multi-cycle sequences; expected outputs go through a scoreboard queue.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int MC_W   = 4;
  localparam int FW     = $clog2(DEPTH);
  localparam int EW     = 3 + 2 * FW + 16;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_rs_used, id_rt_used;
  logic              id_regwrite, id_memread;
  logic [MC_W-1:0]   id_mc_cycles;
  logic              flush;
  logic              stall, bubble, ex_hold;
  logic [FW-1:0]     ex_fwd_a, ex_fwd_b;
  logic [15:0]       stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic              rst, v;
    logic [REG_AW-1:0] rs, rt;
    logic              ru, tu;
    logic [REG_AW-1:0] rd;
    logic              rw, mr;
    logic [MC_W-1:0]   mc;
    logic              fl;
    logic              e_stall, e_bub, e_hold;
    logic [FW-1:0]     e_fa, e_fb;
    logic [15:0]       e_cnt;
  } vec_t;

  vec_t vecs[$];

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW),
    .DEPTH (DEPTH),
    .MC_W  (MC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_mc_cycles(id_mc_cycles),
    .flush       (flush),
    .stall       (stall),
    .bubble      (bubble),
    .ex_hold     (ex_hold),
    .ex_fwd_a    (ex_fwd_a),
    .ex_fwd_b    (ex_fwd_b),
    .stall_cnt   (stall_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs: r v rs rt ru tu rd rw mr mc fl ; expected: stall bubble hold fa fb cnt
  function automatic vec_t mk(input int r, v, rs, rt, ru, tu, rd, rw, mr, mc, fl,
                              input int es, eb, eh, fa, fb, cnt);
    vec_t t;
    t.rst = r[0];   t.v  = v[0];
    t.rs  = REG_AW'(rs); t.rt = REG_AW'(rt);
    t.ru  = ru[0];  t.tu = tu[0];
    t.rd  = REG_AW'(rd);
    t.rw  = rw[0];  t.mr = mr[0];
    t.mc  = MC_W'(mc);
    t.fl  = fl[0];
    t.e_stall = es[0]; t.e_bub = eb[0]; t.e_hold = eh[0];
    t.e_fa = FW'(fa); t.e_fb = FW'(fb);
    t.e_cnt = 16'(cnt);
    return t;
  endfunction

  // Driver: apply one cycle of inputs at negedge, sample before the next posedge
  task automatic step(input vec_t t, input int id);
    logic [EW-1:0] got;
    logic [EW-1:0] expv;
    @(negedge clk);
    rst          = t.rst;
    id_valid     = t.v;
    id_rs        = t.rs;
    id_rt        = t.rt;
    id_rs_used   = t.ru;
    id_rt_used   = t.tu;
    id_rd        = t.rd;
    id_regwrite  = t.rw;
    id_memread   = t.mr;
    id_mc_cycles = t.mc;
    flush        = t.fl;
    exp_q.push_back({t.e_stall, t.e_bub, t.e_hold, t.e_fa, t.e_fb, t.e_cnt});
    #2;
    got  = {stall, bubble, ex_hold, ex_fwd_a, ex_fwd_b, stall_cnt};
    expv = exp_q.pop_front();
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL step%0d got stall=%0b bubble=%0b hold=%0b fwd_a=%0d fwd_b=%0d cnt=%0d exp stall=%0b bubble=%0b hold=%0b fwd_a=%0d fwd_b=%0d cnt=%0d",
               id, stall, bubble, ex_hold, ex_fwd_a, ex_fwd_b, stall_cnt,
               t.e_stall, t.e_bub, t.e_hold, t.e_fa, t.e_fb, t.e_cnt);
    end
  endtask

  initial begin
    // Reset block
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
    id_rt_used = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_mc_cycles = '0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //          r v rs rt ru tu rd rw mr mc fl   st bu eh fa fb cnt
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,0,0,0)); // reset state, idle
    vecs.push_back(mk(0,1, 1, 2,1,1, 3,1,0,0,0,  0,0,0,0,0,0)); // add r3,r1,r2
    vecs.push_back(mk(0,1, 3, 1,1,1, 4,1,0,0,0,  0,0,0,0,0,0)); // add r4,r3,r1
    vecs.push_back(mk(0,1, 2, 0,1,0, 5,1,1,0,0,  0,0,0,1,0,0)); // lw r5 ; EX add r4 fwd a=1
    vecs.push_back(mk(0,1, 5, 5,1,1, 6,1,0,0,0,  1,1,0,0,0,0)); // add r6,r5,r5 load-use
    vecs.push_back(mk(0,1, 5, 5,1,1, 6,1,0,0,0,  0,0,0,0,0,1)); // issues after bubble
    vecs.push_back(mk(0,1, 6, 2,1,1, 7,1,0,3,0,  0,0,0,2,2,1)); // mul r7 mc=3 ; fwd 2/2
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0,0,  1,0,1,1,0,1)); // dependent add held
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0,0,  1,0,1,1,0,2));
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0,0,  1,0,1,1,0,3));
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0,0,  0,0,0,1,0,4)); // add issues
    vecs.push_back(mk(0,1, 1, 2,1,1, 0,1,0,0,0,  0,0,0,1,0,4)); // writes r0 ; add fwd a=1
    vecs.push_back(mk(0,1, 0, 0,1,1, 9,1,0,0,0,  0,0,0,0,0,4)); // reads r0
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,0,0,4)); // r0 reader: no forward
    vecs.push_back(mk(0,1, 1, 0,1,0,10,1,1,0,0,  0,0,0,0,0,4)); // lw r10
    vecs.push_back(mk(0,1,10, 2,1,1,11,1,0,0,1,  0,1,0,0,0,4)); // load-use under flush
    vecs.push_back(mk(0,1,11,10,1,1,12,1,0,0,0,  0,0,0,0,0,4)); // r11 not tracked, r10 stage 2
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,0,2,4));
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,0,0,4));
    vecs.push_back(mk(0,1,12,12,1,0,13,1,0,0,0,  0,0,0,0,0,4)); // r12 only in WB
    vecs.push_back(mk(0,1,13,13,1,0,14,1,0,0,0,  0,0,0,0,0,4)); // WB-only match gives 0
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,1,0,4)); // unused rt gives 0

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Flush during a hold, then reset on the second hold cycle of a 5-cycle op
    step(mk(0,1,14, 0,1,0,15,1,0,5,0,  0,0,0,0,0,4), 100); // mul r15 mc=5
    step(mk(0,1,15, 0,1,0,16,1,0,0,1,  0,0,1,2,0,4), 101); // flush while held
    step(mk(1,1,15, 0,1,0,16,1,0,0,0,  1,0,1,2,0,4), 102); // rst asserted
    step(mk(0,1,15, 0,1,0,16,1,0,0,0,  0,0,0,0,0,0), 103); // hold gone, issues
    step(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,0,0,0), 104); // r15 entry was cleared

    // Fresh count: mc=3 op with a dependent add stalls exactly 3 cycles
    step(mk(0,1, 1, 2,1,1,17,1,0,3,0,  0,0,0,0,0,0), 200);
    step(mk(0,1,17,17,1,1,18,1,0,0,0,  1,0,1,0,0,0), 201);
    step(mk(0,1,17,17,1,1,18,1,0,0,0,  1,0,1,0,0,1), 202);
    step(mk(0,1,17,17,1,1,18,1,0,0,0,  1,0,1,0,0,2), 203);
    step(mk(0,1,17,17,1,1,18,1,0,0,0,  0,0,0,0,0,3), 204);
    step(mk(0,0, 0, 0,0,0, 0,0,0,0,0,  0,1,0,1,1,3), 205);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
